led_pattern_gen: RTL



---
 rtl/led_pkg.sv | 15 +
 rtl/led_pattern_gen_channel.sv | 87 ++++++++
 rtl/led_pattern_gen.sv | 72 +++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator: channel modes and the
// power-on blink settings for channel 0.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } led_mode_t;

    localparam int BOOT_PERIOD = 1000;
    localparam int BOOT_ON     = 500;

endpackage

// File: rtl/led_pattern_gen_channel.sv
// One LED channel: configuration registers, phase counter, lit decode and
// the one-shot completion pulse.
module led_channel
    import led_pkg::*;
#(
    parameter int PW   = 16,
    parameter bit BOOT = 1'b0
) (
    input  logic          CLK_50,
    input  logic          RST,
    input  logic          tick,
    input  logic          wr,
    input  led_mode_t     wr_mode,
    input  logic [PW-1:0] wr_period,
    input  logic [PW-1:0] wr_on,
    output logic          lit,
    output logic          done
);

    led_mode_t     mode;
    logic [PW-1:0] period;
    logic [PW-1:0] on_time;
    logic [PW-1:0] phase;
    logic [PW-1:0] blink_last;

    // A zero period behaves like a period of one so the phase parks at 0.
    always_comb begin
        blink_last = '0;
        if (period != '0) begin
            blink_last = period - PW'(1);
        end
    end

    always_comb begin
        lit = 1'b0;
        case (mode)
            MODE_OFF:     lit = 1'b0;
            MODE_ON:      lit = 1'b1;
            MODE_BLINK:   lit = (phase < on_time);
            MODE_ONESHOT: lit = (phase < on_time);
            default:      lit = 1'b0;
        endcase
    end

    always_ff @(posedge CLK_50) begin
        if (RST) begin
            mode    <= BOOT ? MODE_BLINK : MODE_OFF;
            period  <= BOOT ? PW'(BOOT_PERIOD) : '0;
            on_time <= BOOT ? PW'(BOOT_ON) : '0;
            phase   <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wr) begin
                // A write restarts the channel and suppresses this tick's advance.
                mode    <= wr_mode;
                period  <= wr_period;
                on_time <= wr_on;
                phase   <= '0;
            end else if (tick) begin
                case (mode)
                    MODE_BLINK: begin
                        if (phase >= blink_last) begin
                            phase <= '0;
                        end else begin
                            phase <= phase + PW'(1);
                        end
                    end
                    MODE_ONESHOT: begin
                        if (phase < on_time) begin
                            phase <= phase + PW'(1);
                            if (phase + PW'(1) == on_time) begin
                                mode <= MODE_OFF;
                                done <= 1'b1;
                            end
                        end else begin
                            mode <= MODE_OFF;
                            done <= 1'b1;
                        end
                    end
                    default: phase <= phase;
                endcase
            end
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared 1 ms prescaler, config write
// decode and output polarity around NUM_CH independent channels.
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int TICK_DIV   = 50000,
    parameter int PW         = 16,
    parameter int ACTIVE_LOW = 1,
    parameter int BOOT_BLINK = 1
) (
    input  logic              CLK_50,
    input  logic              RST,
    input  logic              WR_EN,
    input  logic [4:0]        WR_CH,
    input  logic [1:0]        WR_MODE,
    input  logic [PW-1:0]     WR_PERIOD,
    input  logic [PW-1:0]     WR_ON,
    output logic [NUM_CH-1:0] LED,
    output logic [NUM_CH-1:0] DONE,
    output logic              TICK
);

    localparam int   CW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [CW-1:0]     div_cnt;
    logic              div_wrap;
    logic [NUM_CH-1:0] wr_sel;
    logic [NUM_CH-1:0] lit;

    assign div_wrap = (div_cnt == CW'(TICK_DIV - 1));

    always_ff @(posedge CLK_50) begin
        if (RST) begin
            div_cnt <= '0;
            TICK    <= 1'b0;
        end else begin
            TICK    <= div_wrap;
            div_cnt <= div_wrap ? '0 : div_cnt + CW'(1);
        end
    end

    // Out-of-range channel indices match no channel, so the write is dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr_sel[i] = WR_EN && (WR_CH == 5'(i));

        led_channel #(
            .PW   (PW),
            .BOOT ((BOOT_BLINK != 0) && (i == 0))
        ) u_ch (
            .CLK_50    (CLK_50),
            .RST       (RST),
            .tick      (TICK),
            .wr        (wr_sel[i]),
            .wr_mode   (led_mode_t'(WR_MODE)),
            .wr_period (WR_PERIOD),
            .wr_on     (WR_ON),
            .lit       (lit[i]),
            .done      (DONE[i])
        );
    end

    always_ff @(posedge CLK_50) begin
        if (RST) begin
            LED <= {NUM_CH{POL}};
        end else begin
            LED <= lit ^ {NUM_CH{POL}};
        end
    end

endmodule
